// File: rtl/vrased_guard.sv
// VRASED-style security monitor: atomic SMEM entry/exit, irq/DMA exclusion in
// SMEM, and CPU/DMA access control over NREG protected regions, driving a held core reset.

module vrased_guard_lane #(
    parameter logic [15:0] BASE     = 16'h0000,
    parameter logic [15:0] SIZE     = 16'h0000,
    parameter bit          CPU_PROT = 1'b1,
    parameter bit          DMA_PROT = 1'b1
) (
    input  logic [15:0] data_addr,
    input  logic [15:0] dma_addr,
    input  logic        cpu_req,
    input  logic        dma_en,
    input  logic        pc_ok,
    output logic        cpu_viol,
    output logic        dma_viol
);
    // 17-bit end so a region touching 16'hFFFF neither wraps nor truncates; size 0 never hits
    localparam logic [16:0] END = {1'b0, BASE} + {1'b0, SIZE};

    logic cpu_hit, dma_hit;

    assign cpu_hit  = ({1'b0, data_addr} >= {1'b0, BASE}) && ({1'b0, data_addr} < END);
    assign dma_hit  = ({1'b0, dma_addr}  >= {1'b0, BASE}) && ({1'b0, dma_addr}  < END);
    assign cpu_viol = CPU_PROT && cpu_req && cpu_hit && !pc_ok;
    assign dma_viol = DMA_PROT && dma_en && dma_hit;
endmodule

module vrased_guard #(
    parameter int                   NREG          = 4,
    parameter logic [NREG*16-1:0]   REG_BASE      = {16'h6A00, 16'h0400, 16'hFFC0, 16'h0230},
    parameter logic [NREG*16-1:0]   REG_SIZE      = {16'h0020, 16'h0C00, 16'h0020, 16'h0020},
    parameter logic [NREG-1:0]      REG_CPU_PROT  = '1,
    parameter logic [NREG-1:0]      REG_DMA_PROT  = '1,
    parameter logic [15:0]          SMEM_BASE     = 16'hA000,
    parameter logic [15:0]          SMEM_SIZE     = 16'h4000,
    parameter logic [15:0]          RESET_HANDLER = 16'h0000,
    parameter int                   RST_HOLD      = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [15:0]          pc,
    input  logic                 data_en,
    input  logic                 data_wr,
    input  logic [15:0]          data_addr,
    input  logic                 dma_en,
    input  logic [15:0]          dma_addr,
    input  logic                 irq,
    output logic                 reset,
    output logic [NREG*2+3:0]    viol_cause,
    output logic [7:0]           viol_count
);
    localparam int          CW        = NREG*2 + 4;
    localparam logic [16:0] SMEM_END  = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE};
    localparam logic [15:0] SMEM_LAST = 16'(SMEM_END - 17'd2);
    localparam logic [3:0]  HOLD_INIT = 4'(RST_HOLD - 1);

    typedef enum logic [1:0] {OUT, IN, KILL} state_t;

    state_t          state, state_n;
    logic [3:0]      hold_cnt;
    logic [15:0]     prev_pc;
    logic            pc_in_smem, pc_ok, viol;
    logic [NREG-1:0] cpu_viol, dma_viol;
    logic [CW-1:0]   terms;

    assign pc_in_smem = ({1'b0, pc} >= {1'b0, SMEM_BASE}) && ({1'b0, pc} < SMEM_END);
    // The legal entry cycle already counts as trusted for region accesses
    assign pc_ok = (state == IN) || (state == OUT && pc == SMEM_BASE);

    for (genvar i = 0; i < NREG; i++) begin : g_lane
        vrased_guard_lane #(
            .BASE     (REG_BASE[16*i +: 16]),
            .SIZE     (REG_SIZE[16*i +: 16]),
            .CPU_PROT (REG_CPU_PROT[i]),
            .DMA_PROT (REG_DMA_PROT[i])
        ) u_lane (
            .data_addr (data_addr),
            .dma_addr  (dma_addr),
            .cpu_req   (data_en | data_wr),
            .dma_en    (dma_en),
            .pc_ok     (pc_ok),
            .cpu_viol  (cpu_viol[i]),
            .dma_viol  (dma_viol[i])
        );
    end

    always_comb begin
        terms    = '0;
        terms[0] = (state == OUT) && pc_in_smem && (pc != SMEM_BASE);
        terms[1] = (state == IN) && !pc_in_smem && (prev_pc != SMEM_LAST);
        terms[2] = (state == IN) && irq;
        terms[3] = (state == IN) && dma_en;
        terms[4 +: NREG]      = cpu_viol;
        terms[4+NREG +: NREG] = dma_viol;
        // Everything is ignored while the core is held in reset
        if (state == KILL) terms = '0;
    end

    assign viol = |terms;

    always_comb begin
        state_n = state;
        case (state)
            OUT:  if (viol) state_n = KILL;
                  else if (pc == SMEM_BASE) state_n = IN;
            IN:   if (viol) state_n = KILL;
                  else if (!pc_in_smem && prev_pc == SMEM_LAST) state_n = OUT;
            KILL: if (hold_cnt == 4'd0 && pc == RESET_HANDLER) state_n = OUT;
            default: state_n = KILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= KILL;
            hold_cnt   <= 4'd0;
            reset      <= 1'b1;
            prev_pc    <= 16'h0000;
            viol_cause <= '0;
            viol_count <= 8'h00;
        end else begin
            state   <= state_n;
            reset   <= (state_n == KILL);
            prev_pc <= pc;
            if (viol) begin
                hold_cnt   <= HOLD_INIT;
                viol_cause <= terms;
                if (viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
            end else if (state == KILL && hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_vrased_guard.sv
// Directed bench for vrased_guard: region 0 holds the key, region 1 sits at the
// top of memory, region 2 spans 16'h0400..16'h0FFF.
module tb_vrased_guard;
    localparam int NREG = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] pc = 16'h0000;
    logic        data_en = 1'b0, data_wr = 1'b0, dma_en = 1'b0, irq = 1'b0;
    logic [15:0] data_addr = 16'h0000, dma_addr = 16'h0000;
    logic        reset;
    logic [11:0] viol_cause;
    logic [7:0]  viol_count;

    int checks = 0;
    int errors = 0;

    vrased_guard #(
        .NREG     (NREG),
        .REG_BASE ({16'h0230, 16'h0400, 16'hFFC0, 16'h6A00}),
        .REG_SIZE ({16'h0020, 16'h0C00, 16'h0040, 16'h0020}),
        .RST_HOLD (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pc         (pc),
        .data_en    (data_en),
        .data_wr    (data_wr),
        .data_addr  (data_addr),
        .dma_en     (dma_en),
        .dma_addr   (dma_addr),
        .irq        (irq),
        .reset      (reset),
        .viol_cause (viol_cause),
        .viol_count (viol_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Four ticks at the reset handler: three hold cycles, then back to OUT
    task automatic recover();
        data_en = 1'b0; dma_en = 1'b0; irq = 1'b0; pc = 16'h0000;
        repeat (4) tick();
    endtask

    initial begin
        #2 reset_n = 1'b0;
        tick(); tick();
        check("rst_reset", {31'd0, reset}, 32'd1);
        check("rst_cause", {20'd0, viol_cause}, 32'h000);
        check("rst_count", {24'd0, viol_count}, 32'd0);

        reset_n = 1'b1; pc = 16'h0000;
        tick();
        check("release_reset", {31'd0, reset}, 32'd0);

        // legal attestation run
        pc = 16'hA000; tick();
        check("entry_reset", {31'd0, reset}, 32'd0);
        pc = 16'hA002; tick();
        pc = 16'hDFFE; tick();
        pc = 16'h0100; tick();
        check("exit_reset", {31'd0, reset}, 32'd0);
        check("exit_cause", {20'd0, viol_cause}, 32'h000);
        check("exit_count", {24'd0, viol_count}, 32'd0);
        pc = 16'h0100; tick();

        // mid-SMEM jump from OUT
        pc = 16'hA010; tick();
        check("jump_reset", {31'd0, reset}, 32'd1);
        check("jump_cause", {20'd0, viol_cause}, 32'h001);
        check("jump_count", {24'd0, viol_count}, 32'd1);
        // handler presented at once plus a DMA that must be ignored in KILL
        pc = 16'h0000; dma_en = 1'b1; dma_addr = 16'h6A04;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_reset", {31'd0, reset}, 32'd1);
        end
        check("hold_count", {24'd0, viol_count}, 32'd1);
        check("hold_cause", {20'd0, viol_cause}, 32'h001);
        dma_en = 1'b0;
        tick();
        check("hold_release", {31'd0, reset}, 32'd0);

        // key read from outside
        pc = 16'h0200; data_en = 1'b1; data_addr = 16'h6A04; tick();
        check("key_reset", {31'd0, reset}, 32'd1);
        check("key_cause", {20'd0, viol_cause}, 32'h010);
        check("key_count", {24'd0, viol_count}, 32'd2);
        recover();
        check("key_recover", {31'd0, reset}, 32'd0);

        // same read from inside SMEM is legal
        pc = 16'hA000; tick();
        pc = 16'hA004; data_en = 1'b1; data_addr = 16'h6A04; tick();
        check("key_in_reset", {31'd0, reset}, 32'd0);
        check("key_in_count", {24'd0, viol_count}, 32'd2);
        data_en = 1'b0;

        // irq + DMA into region 2 in one cycle
        pc = 16'hA006; irq = 1'b1; dma_en = 1'b1; dma_addr = 16'h0410; tick();
        check("multi_reset", {31'd0, reset}, 32'd1);
        check("multi_cause", {20'd0, viol_cause}, 32'h40C);
        check("multi_count", {24'd0, viol_count}, 32'd3);
        recover();

        // top-of-memory region
        pc = 16'h0100; dma_en = 1'b1; dma_addr = 16'hFFBF; tick();
        check("top_below", {31'd0, reset}, 32'd0);
        dma_addr = 16'hFFFF; tick();
        check("top_reset", {31'd0, reset}, 32'd1);
        check("top_cause", {20'd0, viol_cause}, 32'h200);
        check("top_count", {24'd0, viol_count}, 32'd4);
        recover();

        // drive the counter to saturation
        for (int k = 0; k < 251; k++) begin
            pc = 16'h0100; dma_en = 1'b1; dma_addr = 16'hFFFF; tick();
            recover();
        end
        check("sat_reach", {24'd0, viol_count}, 32'd255);
        for (int k = 0; k < 5; k++) begin
            pc = 16'h0100; dma_en = 1'b1; dma_addr = 16'hFFFF; tick();
            recover();
        end
        check("sat_hold", {24'd0, viol_count}, 32'd255);

        // illegal exit from the middle of SMEM
        pc = 16'hA000; tick();
        pc = 16'hA100; tick();
        pc = 16'h0300; tick();
        check("badexit_reset", {31'd0, reset}, 32'd1);
        check("badexit_cause", {20'd0, viol_cause}, 32'h002);
        check("badexit_count", {24'd0, viol_count}, 32'd255);
        recover();

        // reset_n mid-kill with hold_cnt at 2
        pc = 16'h0100; dma_en = 1'b1; dma_addr = 16'hFFFF; tick();
        dma_en = 1'b0; tick();
        reset_n = 1'b0;
        #1;
        check("midrst_reset", {31'd0, reset}, 32'd1);
        check("midrst_cause", {20'd0, viol_cause}, 32'h000);
        check("midrst_count", {24'd0, viol_count}, 32'd0);
        reset_n = 1'b1; pc = 16'h0000;
        tick();
        check("midrst_release", {31'd0, reset}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
